// File: rtl/decode_ctrl_pipe_if.sv
// decode_ctrl_pipe_if: fetch handshake, stall/flush controls and the registered ID/EX control word.
interface decode_ctrl_pipe_if #(
   parameter int EX_W  = 4,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic [31:0]      instr;
   logic             stall_in;
   logic             flush;
   logic             id_ready;
   logic             ex_valid;
   logic             ex_mem_we;
   logic             ex_reg_we;
   logic             ex_mem_read;
   logic [EX_W-1:0]  ex_alu_op;
   logic [2:0]       ex_imm_op;
   logic [1:0]       ex_jump_t;
   logic [2:0]       ex_branch_t;
   logic             ex_lui;
   logic             ex_auipc;
   logic [4:0]       ex_rd;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic             ex_illegal;
   logic [CNT_W-1:0] illegal_cnt;
   modport master (
      output in_valid, instr, stall_in, flush,
      input  id_ready, ex_valid, ex_mem_we, ex_reg_we, ex_mem_read, ex_alu_op, ex_imm_op,
             ex_jump_t, ex_branch_t, ex_lui, ex_auipc, ex_rd, ex_rs1, ex_rs2, ex_illegal,
             illegal_cnt
   );
   modport slave (
      input  in_valid, instr, stall_in, flush,
      output id_ready, ex_valid, ex_mem_we, ex_reg_we, ex_mem_read, ex_alu_op, ex_imm_op,
             ex_jump_t, ex_branch_t, ex_lui, ex_auipc, ex_rd, ex_rs1, ex_rs2, ex_illegal,
             illegal_cnt
   );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: RV32I decode into a registered ID/EX control word with load-use bubbles and illegal counting.
module decode_ctrl_pipe #(
   parameter int EX_W      = 4,
   parameter bit HAZARD_EN = 1'b1,
   parameter int CNT_W     = 8
) (
   input logic               clk,
   input logic               rst,
   decode_ctrl_pipe_if.slave bus
);
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
      ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
   } alu_e;
   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_NONE} imm_e;
   typedef enum logic [1:0] {JT_NONE, JT_JAL, JT_JALR, JT_BRANCH} jump_e;
   typedef struct packed {
      logic       mem_we;
      logic       reg_we;
      logic       mem_read;
      alu_e       alu_op;
      imm_e       imm_op;
      jump_e      jump_t;
      logic [2:0] branch_t;
      logic       lui;
      logic       auipc;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       illegal;
   } ctrl_t;

   function automatic alu_e alu_sel(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    return alt ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return alt ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   ctrl_t            dec, ex_d, ex_q;
   logic             ex_valid_d, ex_valid_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             use_rs1, use_rs2, legal, wr;
   logic             hit, hazard, id_ready, load, hold;
   logic [6:0]       opc, f7;
   logic [2:0]       f3;

   assign opc = bus.instr[6:0];
   assign f3  = bus.instr[14:12];
   assign f7  = bus.instr[31:25];

   always_comb begin
      dec      = '0;
      dec.rd   = bus.instr[11:7];
      dec.rs1  = bus.instr[19:15];
      dec.rs2  = bus.instr[24:20];
      dec.imm_op = IMM_NONE;
      dec.alu_op = ALU_ADD;
      use_rs1  = 1'b0;
      use_rs2  = 1'b0;
      wr       = 1'b0;
      legal    = 1'b1;
      case (opc)
         OPC_LUI: begin
            dec.imm_op = IMM_U;
            dec.alu_op = ALU_PASSB;
            dec.lui    = 1'b1;
            wr         = 1'b1;
         end
         OPC_AUIPC: begin
            dec.imm_op = IMM_U;
            dec.auipc  = 1'b1;
            wr         = 1'b1;
         end
         OPC_JAL: begin
            dec.imm_op = IMM_J;
            dec.jump_t = JT_JAL;
            wr         = 1'b1;
         end
         OPC_JALR: begin
            dec.imm_op = IMM_I;
            dec.jump_t = JT_JALR;
            wr         = 1'b1;
            use_rs1    = 1'b1;
            legal      = f3 == 3'd0;
         end
         OPC_BRANCH: begin
            dec.imm_op   = IMM_B;
            dec.jump_t   = JT_BRANCH;
            dec.branch_t = f3;
            dec.alu_op   = f3[2:1] == 2'b11 ? ALU_SLTU : ALU_SUB;
            use_rs1      = 1'b1;
            use_rs2      = 1'b1;
            legal        = f3[2:1] != 2'b01;
         end
         OPC_LOAD: begin
            dec.imm_op   = IMM_I;
            dec.mem_read = 1'b1;
            wr           = 1'b1;
            use_rs1      = 1'b1;
            legal        = f3 != 3'd3 && f3[2:1] != 2'b11;
         end
         OPC_STORE: begin
            dec.imm_op = IMM_S;
            dec.mem_we = 1'b1;
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
            legal      = f3 < 3'd3;
         end
         OPC_IMM: begin
            dec.imm_op = IMM_I;
            dec.alu_op = alu_sel(f3, f7[5] && f3 == 3'd5);
            wr         = 1'b1;
            use_rs1    = 1'b1;
            legal      = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
         end
         OPC_OP: begin
            dec.alu_op = alu_sel(f3, f7[5]);
            wr         = 1'b1;
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
            legal      = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         end
         default: legal = 1'b0;
      endcase
      dec.illegal  = !legal;
      dec.reg_we   = wr && legal && dec.rd != 5'd0;
      dec.mem_we   = dec.mem_we && legal;
      dec.mem_read = dec.mem_read && legal;
      dec.jump_t   = legal ? dec.jump_t : JT_NONE;
   end

   // Bubbles, flushed slots and idle loads are written as an all-zero word so enables read 0.
   always_comb begin
      hit        = (use_rs1 && dec.rs1 == ex_q.rd) || (use_rs2 && dec.rs2 == ex_q.rd);
      hazard     = HAZARD_EN && ex_valid_q && ex_q.mem_read && ex_q.rd != 5'd0 && bus.in_valid && hit;
      id_ready   = !bus.stall_in && !hazard;
      load       = !bus.flush && id_ready;
      hold       = bus.stall_in && !bus.flush;
      ex_valid_d = load ? bus.in_valid : hold && ex_valid_q;
      ex_d       = (load && bus.in_valid) ? dec : hold ? ex_q : '0;
      cnt_d      = (load && bus.in_valid && dec.illegal && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
         cnt_q      <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_q       <= ex_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.id_ready    = id_ready;
   assign bus.ex_valid    = ex_valid_q;
   assign bus.ex_mem_we   = ex_q.mem_we;
   assign bus.ex_reg_we   = ex_q.reg_we;
   assign bus.ex_mem_read = ex_q.mem_read;
   assign bus.ex_alu_op   = EX_W'(ex_q.alu_op);
   assign bus.ex_imm_op   = ex_q.imm_op;
   assign bus.ex_jump_t   = ex_q.jump_t;
   assign bus.ex_branch_t = ex_q.branch_t;
   assign bus.ex_lui      = ex_q.lui;
   assign bus.ex_auipc    = ex_q.auipc;
   assign bus.ex_rd       = ex_q.rd;
   assign bus.ex_rs1      = ex_q.rs1;
   assign bus.ex_rs2      = ex_q.rs2;
   assign bus.ex_illegal  = ex_q.illegal;
   assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: random and directed stimulus against a behavioural decode model, checked through a scoreboard.
module tb_decode_ctrl_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decode_ctrl_pipe_if #(.EX_W(4), .CNT_W(2)) bus ();
   decode_ctrl_pipe_if #(.EX_W(4), .CNT_W(8)) bus2 ();

   decode_ctrl_pipe #(.EX_W(4), .HAZARD_EN(1'b1), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   decode_ctrl_pipe #(.EX_W(4), .HAZARD_EN(1'b0), .CNT_W(8)) dut_nh (.clk(clk), .rst(rst), .bus(bus2));

   assign bus2.in_valid = bus.in_valid;
   assign bus2.instr    = bus.instr;
   assign bus2.stall_in = bus.stall_in;
   assign bus2.flush    = bus.flush;

   typedef struct packed {
      logic       illegal;
      logic       mem_we;
      logic       reg_we;
      logic       mem_read;
      logic [3:0] alu;
      logic [2:0] imm;
      logic [1:0] jt;
      logic [2:0] bt;
      logic       lui;
      logic       auipc;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
   } exp_t;

   typedef struct packed {
      logic       v;
      logic       full;
      exp_t       w;
      logic [1:0] cnt;
   } rec_t;

   rec_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;
   bit   m_valid = 1'b0;
   exp_t m_word = '0;
   int   m_cnt = 0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [3:0] op_alu(input logic [2:0] f3, input bit alt);
      logic [3:0] tab [8];
      tab = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
      if (alt && f3 == 3'd0) return 4'd1;
      if (alt && f3 == 3'd5) return 4'd7;
      return tab[f3];
   endfunction

   function automatic exp_t ref_dec(input logic [31:0] i);
      exp_t e;
      logic [2:0] f3;
      logic [6:0] f7;
      bit ok;
      e = '0;
      f3 = i[14:12];
      f7 = i[31:25];
      e.rd = i[11:7];
      e.rs1 = i[19:15];
      e.rs2 = i[24:20];
      e.imm = 3'd5;
      ok = 1'b1;
      case (i[6:0])
         7'h37: begin e.imm = 3'd4; e.alu = 4'd10; e.lui = 1'b1; e.reg_we = 1'b1; end
         7'h17: begin e.imm = 3'd4; e.auipc = 1'b1; e.reg_we = 1'b1; end
         7'h6F: begin e.imm = 3'd3; e.jt = 2'd1; e.reg_we = 1'b1; end
         7'h67: begin e.imm = 3'd0; e.jt = 2'd2; e.reg_we = 1'b1; e.u1 = 1'b1; ok = f3 == 3'd0; end
         7'h63: begin
            e.imm = 3'd2; e.jt = 2'd3; e.bt = f3; e.u1 = 1'b1; e.u2 = 1'b1;
            e.alu = (f3 >= 3'd6) ? 4'd9 : 4'd1;
            ok = !(f3 inside {3'd2, 3'd3});
         end
         7'h03: begin
            e.imm = 3'd0; e.mem_read = 1'b1; e.reg_we = 1'b1; e.u1 = 1'b1;
            ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
         end
         7'h23: begin e.imm = 3'd1; e.mem_we = 1'b1; e.u1 = 1'b1; e.u2 = 1'b1; ok = f3 <= 3'd2; end
         7'h13: begin
            e.imm = 3'd0; e.reg_we = 1'b1; e.u1 = 1'b1;
            e.alu = op_alu(f3, f3 == 3'd5 && f7[5]);
            ok = (f3 == 3'd1) ? f7 == 7'd0 : (f3 == 3'd5) ? f7 inside {7'd0, 7'd32} : 1'b1;
         end
         7'h33: begin
            e.reg_we = 1'b1; e.u1 = 1'b1; e.u2 = 1'b1;
            e.alu = op_alu(f3, f7 == 7'd32);
            ok = f7 == 7'd0 || (f7 == 7'd32 && f3 inside {3'd0, 3'd5});
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e.illegal = 1'b1;
         e.mem_we = 1'b0;
         e.mem_read = 1'b0;
         e.jt = 2'd0;
      end
      if (!ok || e.rd == 5'd0) e.reg_we = 1'b0;
      return e;
   endfunction

   function automatic exp_t mask(input exp_t a, input exp_t m);
      exp_t r;
      r = a;
      r.u1 = m.u1;
      r.u2 = m.u2;
      if (m.illegal) begin
         {r.alu, r.imm, r.bt, r.lui, r.auipc, r.rd, r.rs1, r.rs2, r.u1, r.u2} = '0;
      end else begin
         if (m.jt != 2'd3) r.bt = '0;
         if (!m.u1) r.rs1 = '0;
         if (!m.u2) r.rs2 = '0;
      end
      return r;
   endfunction

   function automatic exp_t act_word();
      exp_t a;
      a = '0;
      a.illegal = bus.ex_illegal;
      a.mem_we = bus.ex_mem_we;
      a.reg_we = bus.ex_reg_we;
      a.mem_read = bus.ex_mem_read;
      a.alu = bus.ex_alu_op;
      a.imm = bus.ex_imm_op;
      a.jt = bus.ex_jump_t;
      a.bt = bus.ex_branch_t;
      a.lui = bus.ex_lui;
      a.auipc = bus.ex_auipc;
      a.rd = bus.ex_rd;
      a.rs1 = bus.ex_rs1;
      a.rs2 = bus.ex_rs2;
      return a;
   endfunction

   always @(negedge clk) begin
      rec_t r;
      exp_t a;
      if (sb.size() != 0) begin
         r = sb.pop_front();
         a = act_word();
         chk(bus.ex_valid === r.v, "ex_valid", 64'(bus.ex_valid), 64'(r.v));
         if (r.full) chk(a === '0, "reset_word", 64'(a), 64'(0));
         else if (r.v) chk(mask(a, r.w) === mask(r.w, r.w), "ex_word", 64'(mask(a, r.w)), 64'(mask(r.w, r.w)));
         else chk({a.mem_we, a.reg_we, a.mem_read} === 3'b0, "bubble_en", 64'({a.mem_we, a.reg_we, a.mem_read}), 64'(0));
         chk(bus.illegal_cnt === r.cnt, "illegal_cnt", 64'(bus.illegal_cnt), 64'(r.cnt));
      end
   end

   task automatic step(input bit r, input bit v, input bit st, input bit fl, input logic [31:0] ins, output bit rdy);
      exp_t d;
      bit hz;
      rec_t rec;
      rst = r;
      bus.in_valid = v;
      bus.instr = ins;
      bus.stall_in = st;
      bus.flush = fl;
      @(negedge clk);
      d = ref_dec(ins);
      hz = m_valid && m_word.mem_read && m_word.rd != 5'd0 && v &&
           ((d.u1 && d.rs1 == m_word.rd) || (d.u2 && d.rs2 == m_word.rd));
      rdy = !st && !hz;
      chk(bus.id_ready === rdy, "id_ready", 64'(bus.id_ready), 64'(rdy));
      chk(bus2.id_ready === !st, "id_ready_nohaz", 64'(bus2.id_ready), 64'(!st));
      @(posedge clk);
      rec.full = r;
      if (r) begin
         m_valid = 1'b0;
         m_word = '0;
         m_cnt = 0;
      end else begin
         if (v && rdy && !fl && d.illegal && m_cnt < 3) m_cnt++;
         if (fl || (!st && hz)) begin
            m_valid = 1'b0;
            m_word = '0;
         end else if (!st) begin
            m_valid = v;
            m_word = v ? d : '0;
         end
      end
      rec.v = m_valid;
      rec.w = m_word;
      rec.cnt = 2'(m_cnt);
      sb.push_back(rec);
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] op, f7;
      logic [2:0] f3;
      int k;
      k = $urandom_range(0, 11);
      case (k)
         0: op = 7'h37;
         1: op = 7'h17;
         2: op = 7'h6F;
         3: op = 7'h67;
         4: op = 7'h63;
         5, 9: op = 7'h03;
         6: op = 7'h23;
         7: op = 7'h13;
         8: op = 7'h33;
         default: op = 7'($urandom);
      endcase
      f3 = 3'($urandom_range(0, 7));
      if (op == 7'h67 && $urandom_range(0, 3) != 0) f3 = 3'd0;
      k = $urandom_range(0, 5);
      f7 = (k < 3) ? 7'h00 : (k < 5) ? 7'h20 : 7'($urandom);
      return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f3, 5'($urandom_range(0, 3)), op};
   endfunction

   initial begin
      bit rdy, pv, prdy;
      logic [31:0] ins;
      step(1, 0, 0, 0, 32'h0, rdy);
      step(1, 0, 0, 0, 32'h0, rdy);
      step(0, 1, 0, 0, 32'h002081B3, rdy);
      step(0, 1, 0, 0, 32'h402081B3, rdy);
      step(0, 1, 0, 0, 32'h0000A283, rdy);
      step(0, 1, 0, 0, 32'h00228333, rdy);
      chk(bus2.ex_valid === 1'b1, "nohaz_valid", 64'(bus2.ex_valid), 64'(1));
      chk(bus2.ex_rd === 5'd6, "nohaz_rd", 64'(bus2.ex_rd), 64'(6));
      chk(bus2.ex_alu_op === 4'd0, "nohaz_alu", 64'(bus2.ex_alu_op), 64'(0));
      step(0, 1, 0, 0, 32'h00228333, rdy);
      step(0, 0, 0, 0, 32'h0, rdy);
      step(0, 1, 0, 0, 32'h002081B3, rdy);
      repeat (3) step(0, 1, 1, 0, 32'h402081B3, rdy);
      step(0, 1, 1, 1, 32'h402081B3, rdy);
      repeat (5) step(0, 1, 0, 0, 32'hFFFFFFFF, rdy);
      step(1, 0, 0, 0, 32'h0, rdy);
      step(0, 1, 0, 0, 32'hFFFFFFFF, rdy);
      step(0, 1, 0, 1, 32'hFFFFFFFF, rdy);
      step(0, 1, 0, 0, 32'h00209463, rdy);
      step(0, 1, 0, 0, 32'h0000006F, rdy);
      step(0, 1, 0, 0, 32'h0000A283, rdy);
      step(1, 1, 1, 1, 32'h002081B3, rdy);
      pv = 1'b0;
      prdy = 1'b1;
      ins = 32'h00000013;
      for (int n = 0; n < 3000; n++) begin
         bit r, v, st, fl;
         if (!(pv && !prdy)) ins = rand_instr();
         r = $urandom_range(0, 99) < 2;
         v = (pv && !prdy) || $urandom_range(0, 9) < 8;
         st = $urandom_range(0, 99) < 15;
         fl = $urandom_range(0, 99) < 8;
         step(r, v, st, fl, ins, rdy);
         pv = v;
         prdy = rdy;
      end
      repeat (3) step(0, 0, 0, 0, 32'h0, rdy);
      @(negedge clk);
      #1;
      chk(sb.size() == 0, "sb_drain", 64'(sb.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered instruction decode stage for the RV32I pipeline. It replaces the flat combinational control decoder: it covers the full RV32I integer ALU set, all six branch conditions and AUIPC. It registers the control word into the ID/EX boundary, detects load-use hazards and inserts bubbles, honours downstream stall and branch flush, and counts illegal instructions.

## Interface
Parameters:
- EX_W, 4, ALU op width; must be ≥ 4.
- HAZARD_EN, 1, enables load-use bubble insertion. When 0, hazard is forced to 0.
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, instr holds a valid fetched instruction.
- instr, in, 32, instruction word.
- stall_in, in, 1, downstream hold request.
- flush, in, 1, branch/jump resolved taken; kills the instruction in ID.
- id_ready, out, 1, ID accepts instr this cycle (combinational).
- ex_valid, out, 1, ID/EX register holds a live instruction.
- ex_mem_we / ex_reg_we / ex_mem_read, out, 1 each, store, register write and load enables.
- ex_alu_op, out, EX_W, ALU operation: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASSB=10.
- ex_imm_op, out, 3, immediate format: I=0, S=1, B=2, J=3, U=4, none=5.
- ex_jump_t, out, 2, control transfer type: none=0, JAL=1, JALR=2, BRANCH=3.
- ex_branch_t, out, 3, branch funct3 passed through (BEQ=0, BNE=1, BLT=4, BGE=5, BLTU=6, BGEU=7).
- ex_lui / ex_auipc, out, 1 each, upper-immediate type.
- ex_rd / ex_rs1 / ex_rs2, out, 5 each, register indices.
- ex_illegal, out, 1, instruction in EX is unrecognised.
- illegal_cnt, out, CNT_W, saturating count of accepted illegal instructions.

## Operation
- Opcodes decoded: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - OP uses funct7/funct3 for all ten ops.
  - OP-IMM decodes ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; funct7 bit 5 selects SRA.
- ALU op for non-ALU instructions:
  - LOAD, STORE, JALR, AUIPC use ADD.
  - BRANCH uses SUB; BLTU and BGEU use SLTU.
  - LUI uses PASSB.
  - JAL uses ADD.
- Register writes: ex_reg_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OP, OP-IMM, and is forced to 0 when rd=0.
- Register usage for hazard purposes:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP, OP-IMM.
  - rs2 is used by BRANCH, STORE, OP.
- Illegal instructions are an unknown opcode, or an unsupported funct3/funct7 combination, or branch funct3 of 2 or 3. For these:
  - ex_illegal=1 and ex_valid=1.
  - All of mem_we, reg_we and mem_read are 0, and jump_t=0.
- hazard = HAZARD_EN & ex_valid & ex_mem_read & ex_rd≠0 & in_valid & the ex_rd match condition.
  - The match condition is: (rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd).
- id_ready = ~stall_in & ~hazard.
- Register update priority, evaluated each clock edge:
  1. rst: all outputs 0, illegal_cnt=0.
  2. flush: ex_valid←0, other ex_* don't care.
  3. stall_in: all ex_* hold.
  4. hazard: ex_valid←0 (bubble).
  5. Otherwise: ex_*←decode(instr), ex_valid←in_valid.
- A bubble or flushed slot has ex_valid=0. Its enables must also read 0; downstream gates on ex_valid anyway.
- illegal_cnt increments by 1 when all of these hold: in_valid, id_ready, ~flush, and instr is illegal.
  - It saturates at 2^CNT_W−1; there is no wrap.

## Timing
- Latency is one cycle: instr accepted at edge N appears on ex_* after edge N.
- id_ready is combinational from stall_in, instr and the ex_* registers.
- A load-use hazard costs exactly one bubble. After the bubble, ex_mem_read=0, so the held instruction issues on the next cycle.
- flush together with stall_in: flush wins, and ex_valid=0 next cycle.
- flush together with hazard: flush wins. id_ready still reads 0 from hazard, so IF holds the instruction.
- rst asserted mid-stream: all ex_* are 0 on the following cycle, regardless of stall_in or flush.
- All outputs reset to 0, including ex_imm_op=0 and illegal_cnt=0.

## Test plan
- Basic ALU decode:
  - in_valid=1, instr=0x002081B3 (add x3,x1,x2) → next cycle ex_valid=1, ex_alu_op=0, ex_reg_we=1, ex_rd=3, ex_rs1=1, ex_rs2=2, ex_imm_op=5.
  - instr=0x402081B3 (sub) → ex_alu_op=1.
- Load-use bubble:
  - Cycle 0: 0x0000A283 (lw x5,0(x1)).
  - Cycle 1: 0x00228333 (add x6,x5,x2) → id_ready=0 in cycle 1; ex_valid=0 in cycle 2; add appears in cycle 3 with ex_rd=6.
  - Repeat with HAZARD_EN=0 → no bubble; add appears in cycle 2.
- Stall/flush:
  - stall_in=1 for 3 cycles while add is in EX → ex_* constant and id_ready=0 throughout.
  - flush=1 with stall_in=1 → ex_valid=0 next cycle.
- Illegal counting with CNT_W=2:
  - Five consecutive 0xFFFFFFFF → ex_illegal=1, ex_reg_we=0, illegal_cnt sequence 1,2,3,3,3.
  - An illegal instruction accepted while flush=1 → count unchanged.
- Branch/jump and reset:
  - 0x00209463 (bne x1,x2,8) → ex_jump_t=3, ex_branch_t=1, ex_imm_op=2, ex_reg_we=0.
  - 0x0000006F (jal x0,0) → ex_jump_t=1, ex_reg_we=0 because rd=0.
  - rst pulsed mid-stream → all outputs 0 next cycle.
